// File: rtl/mix_column_stream.sv
// Streaming AES (Inv)MixColumns: bytes of a column arrive LANES at a time,
// are multiplied by their GF(2^8) coefficients and XOR-accumulated into four
// partial bytes. The finished column moves into an output register that is
// independent of the accumulator, so the next column can build while the
// previous one waits for the consumer.
module mix_column_stream #(
  parameter int LANES = 1,
  parameter int NCOL  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_encrypt,
  input  logic               in_bypass,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [3:0]         out_col,
  output logic               out_last
);

  localparam int         BEATS     = 4 / LANES;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
  localparam logic [3:0] COL_MAX   = 4'(NCOL - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("mix_column_stream: LANES must be 1, 2 or 4");
  end
  if (NCOL < 1 || NCOL > 15) begin : g_bad_ncol
    $error("mix_column_stream: NCOL must be in 1..15");
  end

  // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Contribution of one input byte to one output byte. off is the distance
  // (input position - output position) mod 4, which selects the coefficient.
  function automatic logic [7:0] mix_term(input logic [7:0] x, input logic [1:0] off,
                                          input logic enc, input logic byp);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    mix_term = 8'h00;
    if (byp) begin
      mix_term = (off == 2'd0) ? x : 8'h00;
    end else if (enc) begin
      case (off)
        2'd0:    mix_term = x2;            // 2
        2'd1:    mix_term = x2 ^ x;        // 3
        default: mix_term = x;             // 1
      endcase
    end else begin
      case (off)
        2'd0:    mix_term = x8 ^ x4 ^ x2;  // 14
        2'd1:    mix_term = x8 ^ x2 ^ x;   // 11
        2'd2:    mix_term = x8 ^ x4 ^ x;   // 13
        default: mix_term = x8 ^ x;        // 9
      endcase
    end
  endfunction

  logic [1:0]       beat_q, beat_d;
  logic [3:0][7:0]  part_q, part_d;
  logic             enc_q, enc_d;
  logic             byp_q, byp_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [3:0]       col_q, col_d;

  logic             first_beat;
  logic             last_beat;
  logic             accept;
  logic             out_xfer;
  logic             enc_eff;
  logic             byp_eff;
  logic [7:0]       term [LANES][4];

  // Mode for the beat in flight: live inputs on beat 0, latched copy afterwards.
  assign first_beat = (beat_q == 2'd0);
  assign last_beat  = (beat_q == LAST_BEAT);
  assign enc_eff    = first_beat ? in_encrypt : enc_q;
  assign byp_eff    = first_beat ? in_bypass  : byp_q;

  // Only a final beat needs the output register, so stall just that one.
  assign in_ready = !(last_beat && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [1:0] pos;
    assign pos = 2'(int'(beat_q) * LANES + gi);
    for (genvar gj = 0; gj < 4; gj++) begin : g_out
      logic [1:0] off;
      assign off = pos - 2'(gj);
      assign term[gi][gj] = mix_term(in_data[8*gi +: 8], off, enc_eff, byp_eff);
    end
  end

  // Beat counting, partial accumulation, mode latch and output register next-state.
  always_comb begin
    logic [3:0][7:0] beat_xor;
    beat_xor    = '0;
    beat_d      = beat_q;
    part_d      = part_q;
    enc_d       = enc_q;
    byp_d       = byp_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    col_d       = col_q;

    for (int i = 0; i < 4; i++) begin
      for (int l = 0; l < LANES; l++) begin
        beat_xor[i] = beat_xor[i] ^ term[l][i];
      end
    end

    if (accept) begin
      beat_d = last_beat ? 2'd0 : beat_q + 2'd1;
      // The first beat starts a fresh column, so it overwrites the partials.
      part_d = first_beat ? beat_xor : (part_q ^ beat_xor);
      if (first_beat) begin
        enc_d = in_encrypt;
        byp_d = in_bypass;
      end
    end

    if (out_xfer) begin
      out_valid_d = 1'b0;
      col_d       = (col_q == COL_MAX) ? 4'd0 : col_q + 4'd1;
    end

    // A completing column may overwrite the one leaving this cycle: no bubble.
    if (accept && last_beat) begin
      out_valid_d = 1'b1;
      out_data_d  = part_d;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q      <= 2'd0;
      part_q      <= '0;
      enc_q       <= 1'b1;
      byp_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      col_q       <= 4'd0;
    end else begin
      beat_q      <= beat_d;
      part_q      <= part_d;
      enc_q       <= enc_d;
      byp_q       <= byp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      col_q       <= col_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_col   = col_q;
  assign out_last  = (col_q == COL_MAX);

endmodule

// File: tb/tb_mix_column_stream.sv
// Bench for mix_column_stream: three instances (LANES=1/NCOL=4, LANES=2/NCOL=1,
// LANES=4/NCOL=4) checked against known vectors and a GF(2^8) reference model.
module tb_mix_column_stream;

  localparam int N1 = 4;
  localparam int N2 = 1;
  localparam int N4 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid1, in_ready1, in_enc1, in_byp1, out_valid1, out_ready1, out_last1;
  logic [7:0]  in_data1;
  logic [31:0] out_data1;
  logic [3:0]  out_col1;
  logic        in_valid2, in_ready2, in_enc2, in_byp2, out_valid2, out_ready2, out_last2;
  logic [15:0] in_data2;
  logic [31:0] out_data2;
  logic [3:0]  out_col2;
  logic        in_valid4, in_ready4, in_enc4, in_byp4, out_valid4, out_ready4, out_last4;
  logic [31:0] in_data4;
  logic [31:0] out_data4;
  logic [3:0]  out_col4;

  mix_column_stream #(.LANES(1), .NCOL(N1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .in_encrypt(in_enc1), .in_bypass(in_byp1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_col(out_col1), .out_last(out_last1));
  mix_column_stream #(.LANES(2), .NCOL(N2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .in_encrypt(in_enc2), .in_bypass(in_byp2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_col(out_col2), .out_last(out_last2));
  mix_column_stream #(.LANES(4), .NCOL(N4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .in_encrypt(in_enc4), .in_bypass(in_byp4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .out_col(out_col4), .out_last(out_last4));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (15'(a) << k);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'(9'h11b) << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] a, input logic e, input logic b);
    logic [7:0]  c [4];
    logic [31:0] r;
    logic [7:0]  s;
    if (b) return a;
    if (e) begin c[0] = 8'd2;  c[1] = 8'd3;  c[2] = 8'd1;  c[3] = 8'd1; end
    else   begin c[0] = 8'd14; c[1] = 8'd11; c[2] = 8'd13; c[3] = 8'd9; end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = 8'h00;
      for (int k = 0; k < 4; k++) s = s ^ gmul(c[k], a[8*((i + k) % 4) +: 8]);
      r[8*i +: 8] = s;
    end
    return r;
  endfunction

  // ---------------- scoreboards: {last, col, data} ----------------
  logic [36:0] q1[$], q2[$], q4[$];
  int col1_m = 0, col2_m = 0, col4_m = 0;
  bit gaps_on = 1'b0;

  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) chk("l1_spurious_out", 64'(q1.size()), 64'd1);
      else begin
        e = q1.pop_front();
        chk("l1_out", 64'({out_last1, out_col1, out_data1}), 64'(e));
        $display("l1 col=%0d last=%0b data=%08h", out_col1, out_last1, out_data1);
      end
    end
    if (!rst && out_valid2 && out_ready2) begin
      if (q2.size() == 0) chk("l2_spurious_out", 64'(q2.size()), 64'd1);
      else begin
        e = q2.pop_front();
        chk("l2_out", 64'({out_last2, out_col2, out_data2}), 64'(e));
        $display("l2 col=%0d last=%0b data=%08h", out_col2, out_last2, out_data2);
      end
    end
    if (!rst && out_valid4 && out_ready4) begin
      if (q4.size() == 0) chk("l4_spurious_out", 64'(q4.size()), 64'd1);
      else begin
        e = q4.pop_front();
        chk("l4_out", 64'({out_last4, out_col4, out_data4}), 64'(e));
        $display("l4 col=%0d last=%0b data=%08h", out_col4, out_last4, out_data4);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic beat1(input logic [7:0] d, input logic e, input logic b);
    int n;
    if (gaps_on && $urandom_range(0, 3) == 0) begin in_valid1 = 1'b0; @(posedge clk); #1; end
    in_valid1 = 1'b1; in_data1 = d; in_enc1 = e; in_byp1 = b;
    n = 0;
    @(negedge clk);
    while (!in_ready1 && n < 100) begin @(negedge clk); n++; end
    if (!in_ready1) chk("l1_in_ready_timeout", 64'(in_ready1), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic beat2(input logic [15:0] d, input logic e, input logic b);
    int n;
    if (gaps_on && $urandom_range(0, 3) == 0) begin in_valid2 = 1'b0; @(posedge clk); #1; end
    in_valid2 = 1'b1; in_data2 = d; in_enc2 = e; in_byp2 = b;
    n = 0;
    @(negedge clk);
    while (!in_ready2 && n < 100) begin @(negedge clk); n++; end
    if (!in_ready2) chk("l2_in_ready_timeout", 64'(in_ready2), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic beat4(input logic [31:0] d, input logic e, input logic b);
    int n;
    if (gaps_on && $urandom_range(0, 3) == 0) begin in_valid4 = 1'b0; @(posedge clk); #1; end
    in_valid4 = 1'b1; in_data4 = d; in_enc4 = e; in_byp4 = b;
    n = 0;
    @(negedge clk);
    while (!in_ready4 && n < 100) begin @(negedge clk); n++; end
    if (!in_ready4) chk("l4_in_ready_timeout", 64'(in_ready4), 64'd1);
    @(posedge clk); #1;
  endtask

  // tog inverts both mode inputs on beats after the first; they must be ignored.
  task automatic send_col1(input logic [31:0] a, input logic e, input logic b,
                           input logic tog, input logic [31:0] ex);
    for (int k = 0; k < 4; k++)
      beat1(a[8*k +: 8], (tog && k > 0) ? ~e : e, (tog && k > 0) ? ~b : b);
    q1.push_back({(col1_m == N1 - 1), 4'(col1_m), ex});
    col1_m = (col1_m + 1) % N1;
  endtask

  task automatic send_col2(input logic [31:0] a, input logic e, input logic b,
                           input logic tog, input logic [31:0] ex);
    beat2(a[15:0], e, b);
    beat2(a[31:16], tog ? ~e : e, tog ? ~b : b);
    q2.push_back({(col2_m == N2 - 1), 4'(col2_m), ex});
    col2_m = (col2_m + 1) % N2;
  endtask

  task automatic send_col4(input logic [31:0] a, input logic e, input logic b,
                           input logic [31:0] ex);
    beat4(a, e, b);
    q4.push_back({(col4_m == N4 - 1), 4'(col4_m), ex});
    col4_m = (col4_m + 1) % N4;
  endtask

  task automatic clear_models();
    q1.delete(); q2.delete(); q4.delete();
    col1_m = 0; col2_m = 0; col4_m = 0;
  endtask

  task automatic reset_checks();
    chk("rst_out_valid1", 64'(out_valid1), 64'd0);
    chk("rst_out_data1",  64'(out_data1),  64'd0);
    chk("rst_out_col1",   64'(out_col1),   64'd0);
    chk("rst_out_last1",  64'(out_last1),  64'd0);
    chk("rst_in_ready1",  64'(in_ready1),  64'd1);
    chk("rst_out_valid2", 64'(out_valid2), 64'd0);
    chk("rst_out_last2",  64'(out_last2),  64'd1);
    chk("rst_out_valid4", 64'(out_valid4), 64'd0);
    chk("rst_in_ready4",  64'(in_ready4),  64'd1);
  endtask

  task automatic drain();
    int n;
    in_valid1 = 1'b0; in_valid2 = 1'b0; in_valid4 = 1'b0;
    out_ready1 = 1'b1; out_ready2 = 1'b1; out_ready4 = 1'b1;
    n = 0;
    while ((q1.size() + q2.size() + q4.size()) != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_q1", 64'(q1.size()), 64'd0);
    chk("drain_q2", 64'(q2.size()), 64'd0);
    chk("drain_q4", 64'(q4.size()), 64'd0);
    @(posedge clk); #1;
    chk("drain_idle1", 64'(out_valid1), 64'd0);
    chk("drain_idle2", 64'(out_valid2), 64'd0);
    chk("drain_idle4", 64'(out_valid4), 64'd0);
  endtask

  // ---------------- known-answer table ----------------
  typedef struct {
    int          lanes;
    logic [31:0] a;     // a0 in [7:0]
    logic        enc;
    logic        byp;
    logic        tog;
    logic [31:0] exp;   // b0 in [7:0]
  } vec_t;

  vec_t tv [10];

  initial begin
    logic [31:0] held;
    int          start;

    tv[0] = '{1, 32'h455313db, 1'b1, 1'b0, 1'b0, 32'hbca14d8e};
    tv[1] = '{4, 32'hbca14d8e, 1'b0, 1'b0, 1'b0, 32'h455313db};
    tv[2] = '{4, 32'h5c220af2, 1'b1, 1'b0, 1'b0, 32'h9d58dc9f};
    tv[3] = '{1, 32'h01010101, 1'b1, 1'b1, 1'b1, 32'h01010101};
    tv[4] = '{1, 32'hc6c6c6c6, 1'b1, 1'b1, 1'b1, 32'hc6c6c6c6};
    tv[5] = '{1, 32'hd5d4d4d4, 1'b1, 1'b0, 1'b1, 32'hd6d7d5d5};
    tv[6] = '{4, 32'h4c31262d, 1'b1, 1'b0, 1'b0, 32'hf8bd7e4d};
    tv[7] = '{1, 32'h9d58dc9f, 1'b0, 1'b0, 1'b0, 32'h5c220af2};
    tv[8] = '{1, 32'hf8bd7e4d, 1'b0, 1'b0, 1'b0, 32'h4c31262d};
    tv[9] = '{4, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h12345678};

    in_valid1 = 0; in_data1 = '0; in_enc1 = 0; in_byp1 = 0; out_ready1 = 1;
    in_valid2 = 0; in_data2 = '0; in_enc2 = 0; in_byp2 = 0; out_ready2 = 1;
    in_valid4 = 0; in_data4 = '0; in_enc4 = 0; in_byp4 = 0; out_ready4 = 1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst = 1'b0;

    // Known-answer vectors; result must be valid one cycle after the last beat
    for (int t = 0; t < 10; t++) begin
      if (tv[t].lanes == 1) begin
        send_col1(tv[t].a, tv[t].enc, tv[t].byp, tv[t].tog, tv[t].exp);
        in_valid1 = 1'b0;
        chk($sformatf("kat%0d_valid", t), 64'(out_valid1), 64'd1);
        chk($sformatf("kat%0d_data", t),  64'(out_data1),  64'(tv[t].exp));
      end else begin
        send_col4(tv[t].a, tv[t].enc, tv[t].byp, tv[t].exp);
        in_valid4 = 1'b0;
        chk($sformatf("kat%0d_valid", t), 64'(out_valid4), 64'd1);
        chk($sformatf("kat%0d_data", t),  64'(out_data4),  64'(tv[t].exp));
      end
      @(posedge clk); #1;
    end
    drain();

    // Reset in the middle of a column discards the partial bytes
    rst = 1'b1;
    clear_models();
    @(posedge clk); #1;
    rst = 1'b0;
    beat1(8'hf2, 1'b0, 1'b0);
    beat1(8'h0a, 1'b0, 1'b0);
    in_valid1 = 1'b0;
    #2 rst = 1'b1;
    clear_models();
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst = 1'b0;
    send_col1(32'h455313db, 1'b1, 1'b0, 1'b0, 32'hbca14d8e);
    in_valid1 = 1'b0;
    chk("rst_resume_data", 64'(out_data1), 64'hbca14d8e);
    chk("rst_resume_col",  64'(out_col1),  64'd0);
    drain();

    // Back-pressure: consumer stalls 10 cycles while the producer streams
    rst = 1'b1;
    clear_models();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready1 = 1'b0;
    fork
      begin : stall_src
        logic [31:0] a;
        for (int n = 0; n < 4; n++) begin
          a = $urandom;
          send_col1(a, 1'b1, 1'b0, 1'b0, model_col(a, 1'b1, 1'b0));
        end
        in_valid1 = 1'b0;
      end
      begin : stall_snk
        repeat (5) @(negedge clk);
        held = out_data1;
        chk("stall_first_held", 64'(out_valid1), 64'd1);
        repeat (4) @(negedge clk);
        chk("stall_valid",       64'(out_valid1), 64'd1);
        chk("stall_in_ready",    64'(in_ready1),  64'd0);
        chk("stall_col",         64'(out_col1),   64'd0);
        chk("stall_data_stable", 64'(out_data1),  64'(held));
        repeat (2) @(posedge clk); #1;
        out_ready1 = 1'b1;
      end
    join
    drain();

    // LANES=4 continuous flow: one column per cycle, no bubbles
    start = cyc;
    for (int n = 0; n < 8; n++) begin
      logic [31:0] a;
      logic        e;
      a = $urandom;
      e = 1'($urandom_range(0, 1));
      send_col4(a, e, 1'b0, model_col(a, e, 1'b0));
    end
    chk("l4_throughput_cycles", 64'(cyc - start), 64'd8);
    drain();

    // Randomized traffic with random gaps and random back-pressure
    gaps_on = 1'b1;
    begin
      bit rand_on;
      rand_on = 1'b1;
      fork
        begin
          fork
            begin : r1
              logic [31:0] a; logic e, b, g;
              for (int n = 0; n < 40; n++) begin
                a = $urandom; e = 1'($urandom_range(0, 1));
                b = ($urandom_range(0, 3) == 0); g = 1'($urandom_range(0, 1));
                send_col1(a, e, b, g, model_col(a, e, b));
              end
              in_valid1 = 1'b0;
            end
            begin : r2
              logic [31:0] a; logic e, b, g;
              for (int n = 0; n < 40; n++) begin
                a = $urandom; e = 1'($urandom_range(0, 1));
                b = ($urandom_range(0, 3) == 0); g = 1'($urandom_range(0, 1));
                send_col2(a, e, b, g, model_col(a, e, b));
              end
              in_valid2 = 1'b0;
            end
            begin : r4
              logic [31:0] a; logic e, b;
              for (int n = 0; n < 40; n++) begin
                a = $urandom; e = 1'($urandom_range(0, 1));
                b = ($urandom_range(0, 3) == 0);
                send_col4(a, e, b, model_col(a, e, b));
              end
              in_valid4 = 1'b0;
            end
          join
          rand_on = 1'b0;
        end
        begin : rrdy
          while (rand_on) begin
            out_ready1 = 1'($urandom_range(0, 1));
            out_ready2 = 1'($urandom_range(0, 1));
            out_ready4 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
          end
        end
      join
    end
    gaps_on = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mix_column_stream.md
MIX_COLUMN_STREAM -- requirements
Module: mix_column_stream

Interface
REQ-001 SHALL have parameter LANES, default 1, bytes accepted per input beat; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 SHALL have parameter NCOL, default 4, columns per AES state; legal range 1..15.
REQ-003 clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_ready  output  1  block can accept a beat.
REQ-007 in_data  input  8*LANES  column bytes; the lowest lane carries the earliest byte.
REQ-008 in_encrypt  input  1  1 = MixColumns, 0 = InvMixColumns; sampled on the first beat of a column.
REQ-009 in_bypass  input  1  1 = pass the column unchanged (final round); sampled on the first beat of a column.
REQ-010 out_valid  output  1  out_data holds a finished column.
REQ-011 out_ready  input  1  downstream accepts the column.
REQ-012 out_data  output  32  result column, b0 in [7:0] through b3 in [31:24].
REQ-013 out_col  output  4  column index 0..NCOL-1 of out_data within the state.
REQ-014 out_last  output  1  out_data is column NCOL-1 of the state.

Function
REQ-015 A beat SHALL transfer when in_valid && in_ready; a column SHALL transfer when out_valid && out_ready.
REQ-016 A column a0..a3 SHALL arrive over 4/LANES beats, counted by a beat counter that wraps to 0 after the last beat.
REQ-017 Encrypt mode SHALL compute b_i = 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3), indices mod 4, in GF(2^8) with polynomial 0x11b.
REQ-018 Decrypt mode SHALL compute b_i = 14*a_i ^ 11*a_(i+1) ^ 13*a_(i+2) ^ 9*a_(i+3).
REQ-019 xtime SHALL be (x<<1)[7:0], XORed with 0x1b only when x[7]=1; higher multiples SHALL be built by chained xtime and XOR.
REQ-020 Bypass SHALL take priority over in_encrypt and SHALL give b_i = a_i.
REQ-021 Each accepted byte SHALL be multiplied and XOR-accumulated into four 8-bit partial registers; the first beat SHALL overwrite (not XOR) the partials.
REQ-022 Mode bits SHALL be latched on beat 0; changes on later beats of the same column SHALL be ignored.
REQ-023 On the edge accepting the final beat, the finished column SHALL load into the output register, out_valid SHALL rise, and latency SHALL be 1 cycle from the final beat.
REQ-024 The output register and the accumulator SHALL be independent (2-entry skid), so column k+1 can accumulate while column k waits.
REQ-025 in_ready SHALL be low only when the next beat is a final beat, out_valid=1, and out_ready=0.
REQ-026 When the final beat completes in the same cycle that the held column transfers, the new column SHALL replace it with no bubble.
REQ-027 out_data, out_col and out_last SHALL stay stable while out_valid && !out_ready.
REQ-028 The column counter SHALL advance on each output transfer and wrap from NCOL-1 to 0; out_last SHALL equal (out_col == NCOL-1).
REQ-029 With LANES=4 and continuous flow, throughput SHALL be 1 column per cycle.

Reset
REQ-030 While rst=1: out_valid=0, out_data=0, out_col=0, out_last=(NCOL==1), in_ready=1, beat counter=0, partials=0, and latched mode = encrypt, no bypass.
REQ-031 rst asserted mid-column SHALL discard the partial column; the first beat after release SHALL be treated as beat 0.

Verification
REQ-032 LANES=1, encrypt, bytes db,13,53,45 -> out_data=0x bc a1 4d 8e (b0=8e) one cycle after the 4th beat, out_col=0.
REQ-033 LANES=4, decrypt, in_data with bytes 8e,4d,a1,bc -> b0..b3 = db,13,53,45; then f2,0a,22,5c encrypt -> 9f,dc,58,9d.
REQ-034 Bypass on, encrypt on, column 01,01,01,01 and c6,c6,c6,c6 -> unchanged in both cases; toggling in_encrypt on beats 1-3 has no effect.
REQ-035 NCOL=4, out_ready=0 for 10 cycles with in_valid=1 -> exactly one column is held, the second column stalls at its final beat, no data is lost or reordered, and out_last=1 only on the 4th column.
REQ-036 Assert rst after 2 of 4 beats, release, and send a full column -> result matches that column alone, with out_col=0.
